// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a prescaled count tick, a preset
// load, a wrap pulse, and a time-multiplexed seven-segment display driver.
module bcd_scan_counter #(
  parameter int DIGITS     = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count_out,
  output logic                  wrap,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     an_out
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  // 1 when display outputs are inverted (common anode)
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PW-1:0]          presc_q;
  logic [SW-1:0]          scan_q;
  logic [IW-1:0]          idx_q;
  logic [4*DIGITS-1:0]    count_q;
  logic                   wrap_q;
  logic [6:0]             seg_q;
  logic [DIGITS-1:0]      an_q;

  logic                   tick;
  logic [4*DIGITS-1:0]    count_step_d;
  logic                   step_wrap_d;
  logic [4*DIGITS-1:0]    load_clean_d;
  logic [3:0]             cur_dig_d;
  logic [6:0]             seg_raw_d;
  logic [DIGITS-1:0]      an_hot_d;

  assign tick      = en && (presc_q == PRESC_LAST);
  assign count_out = count_q;
  assign wrap      = wrap_q;
  assign seg_out   = seg_q;
  assign an_out    = an_q;

  // Active-high {g,f,e,d,c,b,a} pattern; anything outside 0..9 is blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Ripple decimal carry/borrow; a carry out of the top digit is the wrap.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    count_step_d = count_q;
    carry        = 1'b1;
    dig          = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (carry) begin
        if (up_down) begin
          if (dig == 4'd9) begin
            count_step_d[4*i +: 4] = 4'd0;
          end else begin
            count_step_d[4*i +: 4] = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            count_step_d[4*i +: 4] = 4'd9;
          end else begin
            count_step_d[4*i +: 4] = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    step_wrap_d = carry;
  end

  // Preset value with illegal (>9) nibbles forced to 0 so the count stays BCD.
  always_comb begin
    load_clean_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_value[4*i +: 4] <= 4'd9)
        load_clean_d[4*i +: 4] = load_value[4*i +: 4];
    end
  end

  // Select the digit under scan and build the one-hot anode pattern.
  always_comb begin
    cur_dig_d = 4'd0;
    an_hot_d  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        cur_dig_d   = count_q[4*i +: 4];
        an_hot_d[i] = 1'b1;
      end
    end
    seg_raw_d = seg_decode(cur_dig_d);
  end

  // Prescaler, count and wrap: reset, then load, then tick.
  always_ff @(posedge clock) begin
    if (!reset) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (load) begin
      presc_q <= '0;
      count_q <= load_clean_d;
      wrap_q  <= 1'b0;
    end else if (tick) begin
      presc_q <= '0;
      count_q <= count_step_d;
      wrap_q  <= step_wrap_d;
    end else begin
      wrap_q <= 1'b0;
      if (en)
        presc_q <= presc_q + 1'b1;
    end
  end

  // Free-running scan divider stepping the digit index round-robin.
  always_ff @(posedge clock) begin
    if (!reset) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SCAN_LAST) begin
      scan_q <= '0;
      idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  // Registered display drive, polarity applied last; blank/deasserted in reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      seg_q <= {7{POL}};
      an_q  <= {DIGITS{POL}};
    end else begin
      seg_q <= seg_raw_d ^ {7{POL}};
      an_q  <= an_hot_d ^ {DIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter (2 digits, tick every 4, scan every 3, active-low).
// Reference model keeps the count as a plain integer 0..99.
module tb_bcd_scan_counter;

  localparam int DIGITS = 2;

  logic        clock = 1'b0;
  logic        reset, en, up_down, load;
  logic [7:0]  load_value;
  logic [7:0]  count_out;
  logic        wrap;
  logic [6:0]  seg_out;
  logic [1:0]  an_out;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int         m_cnt, m_presc, m_scan, m_idx;
  logic       m_wrap;
  logic [6:0] m_seg;
  logic [1:0] m_an;

  logic [6:0] segtbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_scan_counter #(
    .DIGITS(DIGITS), .TICK_DIV(4), .SCAN_DIV(3), .ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_value(load_value), .count_out(count_out), .wrap(wrap),
    .seg_out(seg_out), .an_out(an_out)
  );

  always #5 clock = ~clock;

  function automatic int ld_int(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9) hi = 0;
    if (lo > 9) lo = 0;
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge from the current inputs.
  task automatic model_step();
    logic [1:0] one;
    int         dig;
    one = 2'b01;
    if (!reset) begin
      m_cnt = 0; m_wrap = 1'b0; m_presc = 0; m_scan = 0; m_idx = 0;
      m_seg = 7'h7F; m_an = 2'b11;
    end else begin
      dig   = (m_idx == 0) ? (m_cnt % 10) : (m_cnt / 10);
      m_seg = ~segtbl[dig];
      m_an  = ~(one << m_idx);
      if (load) begin
        m_cnt = ld_int(load_value); m_wrap = 1'b0; m_presc = 0;
      end else if (en && m_presc == 3) begin
        if (up_down) begin
          m_wrap = (m_cnt == 99); m_cnt = (m_cnt + 1) % 100;
        end else begin
          m_wrap = (m_cnt == 0);  m_cnt = (m_cnt + 99) % 100;
        end
        m_presc = 0;
      end else begin
        m_wrap = 1'b0;
        if (en) m_presc++;
      end
      if (m_scan == 2) begin
        m_scan = 0; m_idx = (m_idx + 1) % DIGITS;
      end else begin
        m_scan++;
      end
    end
  endtask

  // One clock: step model, take the edge, compare on the falling edge.
  task automatic cycle();
    model_step();
    @(posedge clock);
    @(negedge clock);
    chk("count", 32'(count_out), 32'(to_bcd(m_cnt)));
    chk("wrap",  32'(wrap),      32'(m_wrap));
    chk("seg",   32'(seg_out),   32'(m_seg));
    chk("an",    32'(an_out),    32'(m_an));
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_value = v;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; up_down = 1'b1; load = 1'b0; load_value = 8'h00;
    m_cnt = 0; m_presc = 0; m_scan = 0; m_idx = 0; m_wrap = 1'b0;
    m_seg = 7'h7F; m_an = 2'b11;

    // Case 1: reset two cycles, release and count up
    cycles(2);
    chk("rst_count", 32'(count_out), 32'h00);
    chk("rst_an",    32'(an_out),    32'h3);
    reset = 1'b1;
    cycles(3);
    chk("c1_pre", 32'(count_out), 32'h00);
    cycle();
    chk("c1_first", 32'(count_out), 32'h01);
    cycles(4);
    chk("c1_second", 32'(count_out), 32'h02);

    // Case 2: 99 wraps up to 00 with a single wrap pulse
    do_load(8'h99);
    cycles(3);
    chk("c2_wrap_pre", 32'(wrap), 32'h0);
    cycle();
    chk("c2_count", 32'(count_out), 32'h00);
    chk("c2_wrap",  32'(wrap),      32'h1);
    cycle();
    chk("c2_wrap_off", 32'(wrap), 32'h0);

    // Case 3: 00 wraps down to 99
    up_down = 1'b0;
    do_load(8'h00);
    cycles(4);
    chk("c3_count", 32'(count_out), 32'h99);
    chk("c3_wrap",  32'(wrap),      32'h1);
    cycle();
    chk("c3_wrap_off", 32'(wrap), 32'h0);

    // Case 4: decimal carry, then illegal nibble sanitised
    up_down = 1'b1;
    do_load(8'h19);
    cycles(4);
    chk("c4_carry", 32'(count_out), 32'h20);
    do_load(8'hA5);
    chk("c4_clean", 32'(count_out), 32'h05);

    // Case 5: hold at 42 while the display scans
    do_load(8'h42);
    en = 1'b0;
    cycles(12);
    chk("c5_hold", 32'(count_out), 32'h42);

    // Direction change mid-period: next tick goes down
    en = 1'b1;
    cycles(2);
    up_down = 1'b0;
    cycles(2);
    chk("dir_change", 32'(count_out), 32'h41);

    // Case 6: load beats a coincident tick, then reset mid-period
    up_down = 1'b1;
    do_load(8'h00);
    cycles(3);
    do_load(8'h10);
    chk("c6_load_wins", 32'(count_out), 32'h10);
    cycles(2);
    reset = 1'b0;
    cycle();
    chk("c6_count", 32'(count_out), 32'h00);
    chk("c6_wrap",  32'(wrap),      32'h0);
    chk("c6_seg",   32'(seg_out),   32'h7F);
    chk("c6_an",    32'(an_out),    32'h3);
    reset = 1'b1;
    cycles(4);
    chk("c6_resume", 32'(count_out), 32'h01);

    // Randomised traffic against the model
    for (int r = 0; r < 600; r++) begin
      reset   = ($urandom_range(0, 59) != 0);
      load    = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0:       load_value = 8'h99;
        1:       load_value = 8'h00;
        default: load_value = 8'($urandom);
      endcase
      en      = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) up_down = ~up_down;
      cycle();
    end
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, number of BCD digits, legal range 1..8.
REQ-002 The block SHALL have parameter TICK_DIV, default 50000000, clock cycles per count step, minimum 2.
REQ-003 The block SHALL have parameter SCAN_DIV, default 50000, clock cycles per display digit slot, minimum 2.
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 1; when 1, seg_out and an_out are active-low (common anode).
REQ-005 Port clock SHALL be an input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 Port reset SHALL be an input, 1 bit, synchronous, active-low (0 = reset).
REQ-007 Port en SHALL be an input, 1 bit, count enable.
REQ-008 Port up_down SHALL be an input, 1 bit, direction: 1 = up, 0 = down.
REQ-009 Port load SHALL be an input, 1 bit, synchronous preset strobe.
REQ-010 Port load_value SHALL be an input, 4*DIGITS bits, preset value; nibble i is digit i, digit 0 is least significant.
REQ-011 Port count_out SHALL be an output, 4*DIGITS bits, the current BCD count.
REQ-012 Port wrap SHALL be an output, 1 bit, one-cycle pulse on a count wrap-around.
REQ-013 Port seg_out SHALL be an output, 7 bits {g,f,e,d,c,b,a}, segment drive for the selected digit.
REQ-014 Port an_out SHALL be an output, DIGITS bits, one-hot digit select.

Function
REQ-015 A prescaler SHALL count 0..TICK_DIV-1 and assert an internal tick in the cycle it equals TICK_DIV-1, then return to 0.
REQ-016 The prescaler SHALL run only while en=1, hold its value while en=0, and clear to 0 on load.
REQ-017 Priority SHALL be: reset, then load, then tick&en.
REQ-018 On load, count_out SHALL take load_value on the next edge; any nibble >9 SHALL be loaded as 0; wrap stays 0.
REQ-019 On tick&en with up_down=1, the count SHALL increment by 1 with decimal carry (digit 9->0 carries into the next digit).
REQ-020 On tick&en with up_down=0, the count SHALL decrement by 1 with decimal borrow (digit 0->9 borrows from the next digit).
REQ-021 Up from all-9s SHALL go to all-0s; down from all-0s SHALL go to all-9s.
REQ-022 wrap SHALL be 1 for exactly the cycle following the wrapping edge, and 0 otherwise.
REQ-023 A change of up_down SHALL take effect on the next tick, with no extra or lost step.
REQ-024 A scan divider SHALL count 0..SCAN_DIV-1 and advance the digit index 0,1,..,DIGITS-1,0 at each terminal count; it is independent of en and load.
REQ-025 seg_out and an_out SHALL be registered.
REQ-026 seg_out and an_out SHALL reflect the digit index and count_out values present one cycle earlier (latency 1).
REQ-027 an_out SHALL assert only bit [index], with polarity per ACTIVE_LOW.
REQ-028 The segment decode SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, active-high {g..a}); values >9 SHALL decode to blank (00).
REQ-029 seg_out SHALL be the bitwise inverse of that decode when ACTIVE_LOW=1.
REQ-030 When DIGITS=1, the digit index SHALL remain 0 and an_out SHALL be constant asserted.

Reset
REQ-031 While reset=0 at a clock edge, the following SHALL clear to 0: count_out, wrap, prescaler, scan divider and digit index.
REQ-032 While reset=0, an_out SHALL be all deasserted and seg_out SHALL be blank, with polarity per ACTIVE_LOW.
REQ-033 A reset asserted mid-count or mid-scan SHALL abort the operation with no pending tick or wrap afterwards.
REQ-034 Counting SHALL resume with a full TICK_DIV period after reset is released.

Verification (DIGITS=2, TICK_DIV=4, SCAN_DIV=3, ACTIVE_LOW=1)
REQ-035 Case 1: reset=0 for 2 cycles, then release with en=1 and up_down=1 -> count_out=00 until the 4th cycle after release, then 01; thereafter +1 every 4 cycles.
REQ-036 Case 2: load 99, then en=1 and up_down=1 -> after 4 cycles count_out=00 and wrap=1 for exactly one cycle.
REQ-037 Case 3: load 00 with up_down=0 -> after one tick count_out=99 and wrap pulses once.
REQ-038 Case 4: load 19, count up -> count_out=20; load_value=8'hA5 -> count_out=05.
REQ-039 Case 5: count=42, en=0 -> an_out alternates 2'b10/2'b01 every 3 cycles; seg_out=~7'h5B with an_out=10 and ~7'h66 with an_out=01; count_out holds.
REQ-040 Case 6: load asserted in the same cycle as a tick, and reset=0 asserted mid-period -> load wins with no increment; after reset count_out=00, wrap=0, seg_out=7'h7F, an_out=2'b11.
